// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, size codes,
// FSM encoding and lane arithmetic.
package mem_stage_lsu_pkg;

  localparam logic [6:0] OP_I2 = 7'b0000011;  // loads
  localparam logic [6:0] OP_S  = 7'b0100011;  // stores

  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;
  localparam logic [1:0] WHB_DBL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  function automatic int lane_count(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data on the way
// out, lane extraction plus sign/zero extension on the way back.
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  whb_i,
  input  logic [$clog2(XLEN/8)-1:0]   lane_i,
  input  logic [XLEN-1:0]             store_i,
  input  logic [XLEN-1:0]             rdata_i,
  input  logic                        su_i,
  output logic [lane_count(XLEN)-1:0] be_o,
  output logic [XLEN-1:0]             wdata_o,
  output logic [XLEN-1:0]             load_o
);

  localparam int NB = lane_count(XLEN);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    load_o  = '0;
    case (whb_i)
      WHB_BYTE: begin
        be_o    = NB'(1) << lane_i;
        wdata_o = {(XLEN/8){store_i[7:0]}};
        load_o  = su_i ? XLEN'(shifted[7:0]) : XLEN'(signed'(shifted[7:0]));
      end
      WHB_HALF: begin
        be_o    = NB'(3) << lane_i;
        wdata_o = {(XLEN/16){store_i[15:0]}};
        load_o  = su_i ? XLEN'(shifted[15:0]) : XLEN'(signed'(shifted[15:0]));
      end
      WHB_WORD: begin
        // At XLEN=32 both casts are identity, so su has no effect.
        be_o    = NB'(15) << lane_i;
        wdata_o = {(XLEN/32){store_i[31:0]}};
        load_o  = su_i ? XLEN'(shifted[31:0]) : XLEN'(signed'(shifted[31:0]));
      end
      default: begin
        be_o    = '1;
        wdata_o = store_i;
        load_o  = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Handshaked MEM stage: registers the EX result, runs one data-memory access
// with wait states and timeout, and presents a one-cycle out_valid to WB.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [6:0]                  opcode,
  input  logic [XLEN-1:0]             result,
  input  logic [XLEN-1:0]             Data_store,
  input  logic [1:0]                  whb,
  input  logic                        su,
  input  logic [XLEN-1:0]             PC_4,
  output logic                        d_req,
  output logic                        d_we,
  output logic [lane_count(XLEN)-1:0] d_be,
  output logic [XLEN-1:0]             d_addr,
  output logic [XLEN-1:0]             d_wdata,
  input  logic                        d_ack,
  input  logic [XLEN-1:0]             d_rdata,
  output logic                        stall,
  output logic                        out_valid,
  output logic [6:0]                  opcode_MEM,
  output logic [XLEN-1:0]             result_MEM,
  output logic [XLEN-1:0]             PC_4_MEM,
  output logic [XLEN-1:0]             Data_out_MEM,
  output logic                        misalign,
  output logic                        bus_err,
  output lsu_state_e                  dbg_state
);

  localparam int NB = lane_count(XLEN);
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic [6:0]      opcode_q;
  logic [XLEN-1:0] result_q, pc4_q, store_q, data_out_q, data_out_d;
  logic [1:0]      whb_q;
  logic            su_q, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_mem_in, mis_in, accept, go_req;
  logic [NB-1:0]   be_w;
  logic [XLEN-1:0] wdata_w, load_w;

  assign is_mem_in = (opcode == OP_I2) || (opcode == OP_S);
  assign accept    = (state_q == S_IDLE) && in_valid;
  assign go_req    = accept && is_mem_in && !mis_in;

  always_comb begin
    mis_in = 1'b0;
    case (whb)
      WHB_HALF: mis_in = result[0];
      WHB_WORD: mis_in = (result[1:0] != 2'b00);
      WHB_DBL:  mis_in = (XLEN == 32) || (result[2:0] != 3'b000);
      default:  mis_in = 1'b0;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .whb_i   (whb_q),
    .lane_i  (result_q[LB-1:0]),
    .store_i (store_q),
    .rdata_i (d_rdata),
    .su_i    (su_q),
    .be_o    (be_w),
    .wdata_o (wdata_w),
    .load_o  (load_w)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
      pc4_q      <= '0;
      store_q    <= '0;
      whb_q      <= '0;
      su_q       <= 1'b0;
      data_out_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      if (accept) begin
        opcode_q <= opcode;
        result_q <= result;
        pc4_q    <= PC_4;
        store_q  <= Data_store;
        whb_q    <= whb;
        su_q     <= su;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          data_out_d = '0;
          bus_err_d  = 1'b0;
          misalign_d = is_mem_in && mis_in;
          state_d    = go_req ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        // An ack in the last allowed cycle still completes normally.
        if (d_ack) begin
          state_d    = S_RESP;
          data_out_d = (opcode_q == OP_I2) ? load_w : '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_RESP;
          bus_err_d  = 1'b1;
          data_out_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request handshake: d_req rises the cycle after accept and d_req/d_we/d_be/
  // d_addr/d_wdata stay constant until the cycle d_ack is sampled high.
  assign d_req        = (state_q == S_REQ);
  assign d_we         = d_req && (opcode_q == OP_S);
  assign d_be         = d_req ? be_w : '0;
  assign d_addr       = result_q & ~XLEN'(NB - 1);
  assign d_wdata      = wdata_w;
  assign stall        = (state_q == S_REQ) || go_req;
  assign out_valid    = (state_q == S_RESP);
  assign opcode_MEM   = opcode_q;
  assign result_MEM   = result_q;
  assign PC_4_MEM     = pc4_q;
  assign Data_out_MEM = data_out_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu at XLEN=32, TIMEOUT=16.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 16;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [6:0]       opcode = '0;
  logic [XLEN-1:0]  result = '0, Data_store = '0, PC_4 = '0;
  logic [1:0]       whb = '0;
  logic             su = 1'b0;
  logic             d_req, d_we;
  logic [3:0]       d_be;
  logic [XLEN-1:0]  d_addr, d_wdata;
  logic             d_ack = 1'b0;
  logic [XLEN-1:0]  d_rdata = '0;
  logic             stall, out_valid, misalign, bus_err;
  logic [6:0]       opcode_MEM;
  logic [XLEN-1:0]  result_MEM, PC_4_MEM, Data_out_MEM;
  lsu_state_e       dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .result(result),
    .Data_store(Data_store), .whb(whb), .su(su), .PC_4(PC_4),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall), .out_valid(out_valid),
    .opcode_MEM(opcode_MEM), .result_MEM(result_MEM), .PC_4_MEM(PC_4_MEM),
    .Data_out_MEM(Data_out_MEM), .misalign(misalign), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] w,
                       input logic s, input logic [31:0] pc);
    in_valid   = 1'b1;
    opcode     = op;
    result     = addr;
    Data_store = data;
    whb        = w;
    su         = s;
    PC_4       = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    #1;
    total_cnt++;
    if ({d_req, d_we, d_be, stall, out_valid, misalign, bus_err} !== 10'b0) begin
      $display("FAIL reset_ctrl got=%b exp=0", {d_req, d_we, d_be, stall, out_valid, misalign, bus_err});
    end else pass_cnt++;
    total_cnt++;
    if ({d_addr, d_wdata, result_MEM, PC_4_MEM, Data_out_MEM, opcode_MEM} !== '0) begin
      $display("FAIL reset_data got nonzero data outputs exp=0");
    end else pass_cnt++;
    total_cnt++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE);
    end else pass_cnt++;
    step();
    rst = 1'b1;
  endtask

  task automatic test_zero_wait_lw();
    drive(OP_I2, 32'h100, 32'h0, WHB_WORD, 1'b0, 32'h4);
    #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL lw_stall_accept got=%b exp=1", stall);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    d_ack    = 1'b1;
    d_rdata  = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if ({d_req, d_we, d_be, d_addr, stall} !== {1'b1, 1'b0, 4'b1111, 32'h100, 1'b1})
      $display("FAIL lw_req got req=%b we=%b be=%b addr=%h stall=%b exp 1 0 1111 100 1",
               d_req, d_we, d_be, d_addr, stall);
    else pass_cnt++;
    step();
    d_ack = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, stall, bus_err, misalign} !== 4'b1000)
      $display("FAIL lw_resp_ctrl got ov=%b stall=%b be=%b mis=%b exp 1 0 0 0", out_valid, stall, bus_err, misalign);
    else pass_cnt++;
    total_cnt++;
    if (Data_out_MEM !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=deadbeef", Data_out_MEM);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if ({out_valid, stall} !== 2'b00) $display("FAIL lw_pulse got ov=%b stall=%b exp 0 0", out_valid, stall);
    else pass_cnt++;
  endtask

  task automatic test_load_extract();
    logic [31:0] addr_t [4] = '{32'h103, 32'h102, 32'h100, 32'h101};
    logic [31:0] rd_t   [4] = '{32'h80FFFFFF, 32'h8001AAAA, 32'h0000F00F, 32'h0000AB00};
    logic [1:0]  whb_t  [4] = '{WHB_BYTE, WHB_HALF, WHB_HALF, WHB_BYTE};
    logic        su_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  be_t   [4] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010};
    logic [31:0] exp_t  [4] = '{32'hFFFFFF80, 32'h00008001, 32'hFFFFF00F, 32'h000000AB};
    for (int i = 0; i < 4; i++) begin
      drive(OP_I2, addr_t[i], 32'h0, whb_t[i], su_t[i], 32'h8);
      step();
      in_valid = 1'b0;
      d_ack    = 1'b1;
      d_rdata  = rd_t[i];
      #1;
      total_cnt++;
      if (d_be !== be_t[i]) $display("FAIL ld_be[%0d] got=%b exp=%b", i, d_be, be_t[i]);
      else pass_cnt++;
      step();
      d_ack = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, Data_out_MEM} !== {1'b1, exp_t[i]})
        $display("FAIL ld_data[%0d] got ov=%b data=%h exp ov=1 data=%h", i, out_valid, Data_out_MEM, exp_t[i]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_store_wait();
    drive(OP_S, 32'h102, 32'h1234ABCD, WHB_HALF, 1'b0, 32'hC);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) d_ack = 1'b1;
      #1;
      total_cnt++;
      if ({d_req, d_we, d_be, d_addr, d_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h100, 32'hABCDABCD})
        $display("FAIL sh_hold[%0d] got req=%b we=%b be=%b addr=%h wdata=%h exp 1 1 1100 100 abcdabcd",
                 c, d_req, d_we, d_be, d_addr, d_wdata);
      else pass_cnt++;
      step();
    end
    d_ack = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, d_req, Data_out_MEM} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL sh_resp got ov=%b req=%b data=%h exp 1 0 0", out_valid, d_req, Data_out_MEM);
    else pass_cnt++;
    step();
  endtask

  task automatic test_misalign();
    logic [31:0] addr_t [3] = '{32'h101, 32'h102, 32'h000};
    logic [1:0]  whb_t  [3] = '{WHB_WORD, WHB_WORD, WHB_DBL};
    logic [6:0]  op_t   [3] = '{OP_I2, OP_S, OP_S};
    for (int i = 0; i < 3; i++) begin
      drive(op_t[i], addr_t[i], 32'h55, whb_t[i], 1'b0, 32'h10);
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL mis_stall[%0d] got=%b exp=0", i, stall);
      else pass_cnt++;
      step();
      in_valid = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, misalign, d_req, bus_err, Data_out_MEM} !== {4'b1100, 32'h0})
        $display("FAIL mis_resp[%0d] got ov=%b mis=%b req=%b berr=%b data=%h exp 1 1 0 0 0",
                 i, out_valid, misalign, d_req, bus_err, Data_out_MEM);
      else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (d_req !== 1'b0) $display("FAIL mis_noreq[%0d] got=%b exp=0", i, d_req);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_timeout(input logic ack_last);
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    drive(OP_I2, 32'h200, 32'h0, WHB_WORD, 1'b0, 32'h14);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      d_ack = 1'b0;
      #1;
      if (out_valid) got = 1'b1;
      else begin
        if (d_req) n++;
        if (ack_last && n == TO) begin
          d_ack   = 1'b1;
          d_rdata = 32'h13579BDF;
        end
        step();
      end
    end
    total_cnt++;
    if (!got || n != TO)
      $display("FAIL to_reqcycles[ack=%b] got done=%b req_cycles=%0d exp done=1 req_cycles=%0d", ack_last, got, n, TO);
    else pass_cnt++;
    total_cnt++;
    if (ack_last) begin
      if ({bus_err, d_req, Data_out_MEM} !== {2'b00, 32'h13579BDF})
        $display("FAIL to_ack_last got berr=%b req=%b data=%h exp 0 0 13579bdf", bus_err, d_req, Data_out_MEM);
      else pass_cnt++;
    end else begin
      if ({bus_err, d_req, Data_out_MEM} !== {2'b10, 32'h0})
        $display("FAIL to_buserr got berr=%b req=%b data=%h exp 1 0 0", bus_err, d_req, Data_out_MEM);
      else pass_cnt++;
    end
    step();
  endtask

  task automatic test_reset_mid_req();
    drive(OP_I2, 32'h300, 32'h0, WHB_WORD, 1'b0, 32'h18);
    step();
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (d_req !== 1'b1) $display("FAIL rmid_req got=%b exp=1", d_req);
    else pass_cnt++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({d_req, stall, dbg_state} !== {2'b00, S_IDLE})
      $display("FAIL rmid_drop got req=%b stall=%b st=%0d exp 0 0 0", d_req, stall, dbg_state);
    else pass_cnt++;
    d_ack   = 1'b1;
    d_rdata = 32'hFFFF0000;
    step();
    d_ack = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, d_req, Data_out_MEM} !== {2'b00, 32'h0})
      $display("FAIL rmid_late_ack got ov=%b req=%b data=%h exp 0 0 0", out_valid, d_req, Data_out_MEM);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    drive(OP_ADD, 32'hCAFE0001, 32'h0, WHB_WORD, 1'b0, 32'h44);
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL add_stall got=%b exp=0", stall);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, opcode_MEM, result_MEM, PC_4_MEM, Data_out_MEM, misalign} !==
        {1'b1, OP_ADD, 32'hCAFE0001, 32'h44, 32'h0, 1'b0})
      $display("FAIL add_pass got ov=%b op=%h res=%h pc=%h data=%h mis=%b exp 1 33 cafe0001 44 0 0",
               out_valid, opcode_MEM, result_MEM, PC_4_MEM, Data_out_MEM, misalign);
    else pass_cnt++;
    step();
    drive(OP_ADD, 32'h00000777, 32'h0, WHB_BYTE, 1'b0, 32'h48);
    step();
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, result_MEM, PC_4_MEM} !== {1'b1, 32'h777, 32'h48})
      $display("FAIL b2b_second got ov=%b res=%h pc=%h exp 1 777 48", out_valid, result_MEM, PC_4_MEM);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_pulse got=%b exp=0", out_valid);
    else pass_cnt++;
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_zero_wait_lw();
    test_load_extract();
    test_store_wait();
    test_misalign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
